// File: rtl/cram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cram_bus_arbiter
// Purpose  : Shares the single-port colour RAM between CPU (CRAMCS) accesses
//            and video pixel fetches. Video has priority; a stall counter
//            forces a starved CPU in. Optional macro CRAM_SNOW_EN selects
//            hardware "snow" emulation (CPU always wins collisions).
// Revision : 1.0 - initial release
// ============================================================================
module cram_bus_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int MAX_STALL = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_ce,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_miss,
  input  logic          cpu_cs_n,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_rdy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_dout,
  input  logic [DW-1:0] ram_din,
  output logic          ram_we_n,
  output logic          ram_oe_n
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_PEND = 2'd1,
    C_ACC  = 2'd2,
    C_DONE = 2'd3
  } cpu_state_t;

  cpu_state_t    r_state;
  cpu_state_t    w_state_nxt;

  logic          w_pending;
  logic          w_vid_slot;
  logic          w_cpu_slot;
  logic          w_vid_drop;
  logic          w_snow;

  logic          r_acc_rd;
  logic          r_vid_p1;
  logic          r_miss_p1;
  logic          r_snow_p1;
  logic          r_snow_wr;
  logic [DW-1:0] r_snow_wdata;

  // A pending CPU only competes for the slot while CS is still asserted.
  assign w_pending = (r_state == C_PEND) && !cpu_cs_n;

`ifdef CRAM_SNOW_EN
  assign w_cpu_slot = w_pending;
  assign w_vid_slot = pix_ce && !w_pending;
  assign w_snow     = pix_ce && w_pending;
  assign w_vid_drop = 1'b0;
`else
  localparam logic [3:0] c_max_stall = 4'(MAX_STALL);

  logic [3:0] r_stall;
  logic       w_force;

  assign w_force    = w_pending && (r_stall == c_max_stall);
  assign w_vid_slot = pix_ce && !w_force;
  assign w_cpu_slot = w_pending && !w_vid_slot;
  assign w_vid_drop = pix_ce && w_force;
  assign w_snow     = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (w_pending && w_vid_slot) begin
      r_stall <= r_stall + 4'd1;
    end else begin
      r_stall <= '0;
    end
  end
`endif

  assign cpu_rdy = !(!cpu_cs_n && (r_state != C_DONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: if (!cpu_cs_n) w_state_nxt = C_PEND;
      C_PEND: begin
        if (cpu_cs_n)        w_state_nxt = C_IDLE;
        else if (w_cpu_slot) w_state_nxt = C_ACC;
      end
      C_ACC:  w_state_nxt = C_DONE;
      C_DONE: if (cpu_cs_n) w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM port: one registered slot per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
      ram_dout <= '0;
      ram_we_n <= 1'b1;
      ram_oe_n <= 1'b1;
      r_acc_rd <= 1'b0;
    end else if (w_vid_slot) begin
      ram_addr <= vid_addr;
      ram_oe_n <= 1'b0;
      ram_we_n <= 1'b1;
    end else if (w_cpu_slot) begin
      ram_addr <= cpu_addr;
      ram_oe_n <= !cpu_rw;
      ram_we_n <= cpu_rw;
      ram_dout <= cpu_din;
      r_acc_rd <= cpu_rw;
    end else begin
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout <= '0;
    end else if ((r_state == C_ACC) && r_acc_rd) begin
      cpu_dout <= ram_din;
    end
  end

  // Video answer pipeline: slot cycle, RAM data cycle, answer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_p1     <= 1'b0;
      r_miss_p1    <= 1'b0;
      r_snow_p1    <= 1'b0;
      r_snow_wr    <= 1'b0;
      r_snow_wdata <= '0;
    end else begin
      r_vid_p1  <= w_vid_slot;
      r_miss_p1 <= w_vid_drop;
      r_snow_p1 <= w_snow;
      if (w_snow) begin
        r_snow_wr    <= !cpu_rw;
        r_snow_wdata <= cpu_din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_data  <= '0;
      vid_valid <= 1'b0;
      vid_miss  <= 1'b0;
    end else begin
      vid_valid <= r_vid_p1 || r_snow_p1;
      vid_miss  <= r_miss_p1 || r_snow_p1;
      if (r_vid_p1) begin
        vid_data <= ram_din;
      end else if (r_snow_p1) begin
        // Snow: video sees whatever the CPU put on the bus.
        vid_data <= r_snow_wr ? r_snow_wdata : ram_din;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cram_bus_arbiter
// Purpose  : Directed self-checking bench for cram_bus_arbiter with a
//            synchronous RAM model (registered address, data next cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cram_bus_arbiter;

  localparam int AW        = 11;
  localparam int DW        = 8;
  localparam int MAX_STALL = 4;

  logic          clk;
  logic          reset_n;
  logic          pix_ce;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_miss;
  logic          cpu_cs_n;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_rdy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] ram_din;
  logic          ram_we_n;
  logic          ram_oe_n;

  cram_bus_arbiter #(.AW(AW), .DW(DW), .MAX_STALL(MAX_STALL)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pix_ce   (pix_ce),
    .vid_addr (vid_addr),
    .vid_data (vid_data),
    .vid_valid(vid_valid),
    .vid_miss (vid_miss),
    .cpu_cs_n (cpu_cs_n),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_rdy  (cpu_rdy),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din),
    .ram_we_n (ram_we_n),
    .ram_oe_n (ram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro model: address registered by the DUT, data visible the next cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_din = mem[ram_addr];
  always @(posedge clk) if (!ram_we_n) mem[ram_addr] <= ram_dout;

  int            vv_cnt = 0;
  int            vm_cnt = 0;
  int            both_cnt = 0;
  int            we_cnt = 0;
  logic [DW-1:0] last_vd = '0;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;

  always @(negedge clk) begin
    if (vid_valid) begin
      vv_cnt  <= vv_cnt + 1;
      last_vd <= vid_data;
    end
    if (vid_miss) vm_cnt <= vm_cnt + 1;
    if (vid_valid && vid_miss) both_cnt <= both_cnt + 1;
    if (!ram_we_n) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= ram_addr;
      last_wd <= ram_dout;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: no video, 1: one pix_ce in the first pending cycle, 2: pix_ce held
  task automatic cpu_access(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int mode, output int rdy_low, output logic [DW-1:0] dout);
    rdy_low  = 0;
    cpu_cs_n = 1'b0;
    cpu_rw   = rw;
    cpu_addr = a;
    cpu_din  = d;
    pix_ce   = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (cpu_rdy) break;
      rdy_low++;
      if (i == 1 && mode != 0) pix_ce = 1'b1;
      if (i == 2 && mode == 1) pix_ce = 1'b0;
    end
    dout     = cpu_dout;
    pix_ce   = 1'b0;
    cpu_cs_n = 1'b1;
  endtask

  int            rl;
  logic [DW-1:0] dv;
  int            vv0, vm0, both0, we0;

  initial begin
    reset_n  = 1'b1;
    pix_ce   = 1'b0;
    vid_addr = '0;
    cpu_cs_n = 1'b1;
    cpu_rw   = 1'b1;
    cpu_addr = '0;
    cpu_din  = '0;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we_n", ram_we_n, 1);
    check_eq("rst_oe_n", ram_oe_n, 1);
    check_eq("rst_rdy", cpu_rdy, 1);
    check_eq("rst_vid_valid", vid_valid, 0);
    check_eq("rst_cpu_dout", cpu_dout, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    reset_n = 1'b1;
    idle(2);

    // Preload palette entry used by video, then plain write/read.
    cpu_access(1'b0, 11'h010, 8'h3C, 0, rl, dv);
    idle(2);
    we0 = we_cnt;
    cpu_access(1'b0, 11'h123, 8'hA5, 0, rl, dv);
    idle(2);
    check_eq("wr_rdy_low", rl, 2);
    check_eq("wr_we_cycles", we_cnt - we0, 1);
    check_eq("wr_addr", last_wa, 11'h123);
    check_eq("wr_data", last_wd, 8'hA5);
    cpu_access(1'b1, 11'h123, 8'h00, 0, rl, dv);
    idle(2);
    check_eq("rd_rdy_low", rl, 2);
    check_eq("rd_dout", dv, 8'hA5);

    // Video only: answer exactly two clocks after pix_ce.
    vid_addr = 11'h010;
    pix_ce   = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    check_eq("vid_lat1_valid", vid_valid, 0);
    @(posedge clk); #1;
    check_eq("vid_lat2_valid", vid_valid, 1);
    check_eq("vid_lat2_data", vid_data, 8'h3C);
    @(posedge clk); #1;
    check_eq("vid_lat3_valid", vid_valid, 0);
    idle(2);

    // Collision on a CPU read.
    vv0 = vv_cnt; vm0 = vm_cnt; both0 = both_cnt;
    cpu_access(1'b1, 11'h123, 8'h00, 1, rl, dv);
    idle(3);
    check_eq("col_rd_dout", dv, 8'hA5);
    check_eq("col_rd_vv", vv_cnt - vv0, 1);
`ifdef CRAM_SNOW_EN
    check_eq("col_rd_rdy_low", rl, 2);
    check_eq("col_rd_vm", vm_cnt - vm0, 1);
    check_eq("col_rd_both", both_cnt - both0, 1);
    check_eq("col_rd_vdata", last_vd, 8'hA5);
`else
    check_eq("col_rd_rdy_low", rl, 3);
    check_eq("col_rd_vm", vm_cnt - vm0, 0);
    check_eq("col_rd_both", both_cnt - both0, 0);
    check_eq("col_rd_vdata", last_vd, 8'h3C);
`endif

    // Saturated video with a pending CPU read.
    vv0 = vv_cnt; vm0 = vm_cnt; both0 = both_cnt;
    cpu_access(1'b1, 11'h123, 8'h00, 2, rl, dv);
    idle(4);
    check_eq("stv_dout", dv, 8'hA5);
    check_eq("stv_vm", vm_cnt - vm0, 1);
`ifdef CRAM_SNOW_EN
    check_eq("stv_rdy_low", rl, 2);
    check_eq("stv_vv", vv_cnt - vv0, 2);
    check_eq("stv_both", both_cnt - both0, 1);
`else
    check_eq("stv_rdy_low", rl, 6);
    check_eq("stv_vv", vv_cnt - vv0, 5);
    check_eq("stv_both", both_cnt - both0, 0);
`endif

    // Collision on a CPU write.
    vm0 = vm_cnt; both0 = both_cnt;
    cpu_access(1'b0, 11'h300, 8'h77, 1, rl, dv);
    idle(3);
`ifdef CRAM_SNOW_EN
    check_eq("col_wr_rdy_low", rl, 2);
    check_eq("col_wr_vm", vm_cnt - vm0, 1);
    check_eq("col_wr_both", both_cnt - both0, 1);
    check_eq("col_wr_vdata", last_vd, 8'h77);
`else
    check_eq("col_wr_rdy_low", rl, 3);
    check_eq("col_wr_vm", vm_cnt - vm0, 0);
    check_eq("col_wr_both", both_cnt - both0, 0);
    check_eq("col_wr_vdata", last_vd, 8'h3C);
`endif
    cpu_access(1'b1, 11'h300, 8'h00, 0, rl, dv);
    idle(2);
    check_eq("col_wr_readback", dv, 8'h77);

`ifndef CRAM_SNOW_EN
    // Abort: CS withdrawn while losing to video, no RAM write may happen.
    cpu_access(1'b0, 11'h200, 8'h11, 0, rl, dv);
    idle(2);
    we0      = we_cnt;
    cpu_cs_n = 1'b0;
    cpu_rw   = 1'b0;
    cpu_addr = 11'h200;
    cpu_din  = 8'h55;
    pix_ce   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_rdy_pend", cpu_rdy, 0);
    cpu_cs_n = 1'b1;
    #1;
    check_eq("abort_rdy_raise", cpu_rdy, 1);
    @(posedge clk); #1;
    pix_ce = 1'b0;
    idle(3);
    check_eq("abort_no_write", we_cnt - we0, 0);
    cpu_access(1'b1, 11'h200, 8'h00, 0, rl, dv);
    idle(2);
    check_eq("abort_readback", dv, 8'h11);
`endif

    // Reset in the middle of a write cycle.
    cpu_access(1'b0, 11'h400, 8'h22, 0, rl, dv);
    idle(2);
    cpu_cs_n = 1'b0;
    cpu_rw   = 1'b0;
    cpu_addr = 11'h400;
    cpu_din  = 8'h99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("mw_we_low", ram_we_n, 0);
    reset_n = 1'b0;
    #1;
    check_eq("mw_we_n_async", ram_we_n, 1);
    check_eq("mw_oe_n_async", ram_oe_n, 1);
    cpu_cs_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);
    cpu_access(1'b1, 11'h400, 8'h00, 0, rl, dv);
    idle(2);
    check_eq("mw_rd_rdy_low", rl, 2);
    check_eq("mw_readback", dv, 8'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
